// File: rtl/ooo_isa_pkg.sv
// Shared ISA definitions for the instruction receive path.
// Word layout is {op, rd, rs1, rs2}, three bits each.
package ooo_isa_pkg;

    localparam int INSTR_W = 12;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_LD   = 3'b101,
        OP_RSVD = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef struct packed {
        opcode_t    op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
    } instr_t;

    function automatic logic is_load(instr_t i);
        return i.op == OP_LD;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy count.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module rx_sync_fifo
    import ooo_isa_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = instr_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;

    T                mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_rx_frontend.sv
// Frames the io_in program stream, captures each word, and queues it for issue.
// Define RX_ILLEGAL_TRAP_EN to abort the stream on the reserved opcode.
module instr_rx_frontend
    import ooo_isa_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [11:0]              io_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_op,
    output logic [2:0]               out_rd,
    output logic [2:0]               out_rs1,
    output logic [2:0]               out_rs2,
    output logic                     out_is_load,
    output logic                     stream_done,
    output logic                     drained,
    output logic                     overflow,
`ifdef RX_ILLEGAL_TRAP_EN
    output logic                     illegal_op,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    instr_t     cap_q, cap_d;
    logic       cap_vld_q, cap_vld_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d;
`ifdef RX_ILLEGAL_TRAP_EN
    logic       ill_q, ill_d;
`endif

    instr_t     word;
    instr_t     head;
    logic       take;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    assign word = instr_t'(io_in);
    assign pop  = ~fifo_empty & out_ready;

    rx_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (instr_t)
    ) u_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (cap_vld_q),
        .wdata (cap_q),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        cap_vld_d = 1'b0;
        done_d    = done_q;
        ovf_d     = ovf_q | (cap_vld_q & fifo_full & ~pop);
`ifdef RX_ILLEGAL_TRAP_EN
        ill_d     = ill_q;
`endif
        case (state_q)
            S_IDLE:  take = (io_in != '0);
            S_RUN:   take = 1'b1;
            default: take = 1'b0;
        endcase
        if (take) begin
            if (word.op == OP_HALT) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
`ifdef RX_ILLEGAL_TRAP_EN
            else if (word.op == OP_RSVD) begin
                state_d = S_DONE;
                ill_d   = 1'b1;
            end
`endif
            else begin
                state_d   = S_RUN;
                cap_d     = word;
                cap_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef RX_ILLEGAL_TRAP_EN
            ill_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
`ifdef RX_ILLEGAL_TRAP_EN
            ill_q     <= ill_d;
`endif
        end
    end

    // Head fields are forced to zero while the FIFO is empty
    assign out_valid   = ~fifo_empty;
    assign out_op      = out_valid ? head.op  : 3'd0;
    assign out_rd      = out_valid ? head.rd  : 3'd0;
    assign out_rs1     = out_valid ? head.rs1 : 3'd0;
    assign out_rs2     = out_valid ? head.rs2 : 3'd0;
    assign out_is_load = out_valid & is_load(head);
    assign stream_done = done_q;
    assign drained     = done_q & fifo_empty;
    assign overflow    = ovf_q;
`ifdef RX_ILLEGAL_TRAP_EN
    assign illegal_op  = ill_q;
`endif

endmodule

// File: tb/tb_instr_rx_frontend.sv
// Randomized and directed checks of instr_rx_frontend against a queue-based model.
// Optional RX_ILLEGAL_TRAP_EN build adds the reserved-opcode abort scenario.
module tb_instr_rx_frontend;
    import ooo_isa_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] io_in;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  out_op, out_rd, out_rs1, out_rs2;
    logic        out_is_load;
    logic        stream_done;
    logic        drained;
    logic        overflow;
    logic [3:0]  occupancy;
    logic        ill_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] mq[$];
    logic        m_pend_v;
    logic [11:0] m_pend;
    int          m_phase;
    logic        m_done, m_ovf, m_ill;
    logic [11:0] prog[8];

    instr_rx_frontend #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_in       (io_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_is_load (out_is_load),
        .stream_done (stream_done),
        .drained     (drained),
        .overflow    (overflow),
`ifdef RX_ILLEGAL_TRAP_EN
        .illegal_op  (ill_w),
`endif
        .occupancy   (occupancy)
    );

`ifndef RX_ILLEGAL_TRAP_EN
    assign ill_w = 1'b0;
`endif

    always #5 clock = ~clock;

    function automatic logic [11:0] mk(input int op, input int rd,
                                       input int rs1, input int rs2);
        return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0]};
    endfunction

    // Expected observable state derived from the model queue and flags
    function automatic logic [21:0] exp_vec();
        logic [11:0] h;
        logic        v;
        v = (mq.size() != 0);
        h = v ? mq[0] : 12'h000;
        return {v, h, v && (h[11:9] == 3'd5), 4'(mq.size()),
                m_done, m_done && !v, m_ovf, m_ill};
    endfunction

    function automatic logic [21:0] got_vec();
        logic [11:0] h;
        h = out_valid ? {out_op, out_rd, out_rs1, out_rs2} : 12'h000;
        return {out_valid, h, out_is_load, occupancy,
                stream_done, drained, overflow, ill_w};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_pend_v = 1'b0;
        m_pend   = '0;
        m_phase  = 0;
        m_done   = 1'b0;
        m_ovf    = 1'b0;
        m_ill    = 1'b0;
    endtask

    // Drive one word for one clock and advance the model by one edge
    task automatic step(input logic [11:0] w, input logic rdy);
        logic full, pop;
        io_in     = w;
        out_ready = rdy;
        @(posedge clock);
        full = (mq.size() == DEPTH);
        pop  = rdy && (mq.size() != 0);
        if (pop) void'(mq.pop_front());
        if (m_pend_v) begin
            if (!full || pop) mq.push_back(m_pend);
            else m_ovf = 1'b1;
        end
        m_pend_v = 1'b0;
        if (m_phase != 2 && !(m_phase == 0 && w == 12'h000)) begin
            if (w[11:9] == 3'd7) begin
                m_phase = 2;
                m_done  = 1'b1;
            end
`ifdef RX_ILLEGAL_TRAP_EN
            else if (w[11:9] == 3'd6) begin
                m_phase = 2;
                m_ill   = 1'b1;
            end
`endif
            else begin
                m_phase  = 1;
                m_pend   = w;
                m_pend_v = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        io_in     = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3);
        n_tests++;
        if (got_vec() !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", got_vec(), 22'h0);
        end
    endtask

    task automatic test_stream();
        logic [21:0] g, e;
        do_reset(3);
        for (int i = 0; i < 3; i++) step(12'h000, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(i < 8 ? prog[i] : 12'h000, 1'b1);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL stream cyc %0d got %h want %h", i, g, e);
            end
            if (i == 0) begin
                n_tests++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_latency_early got %b want 0", out_valid);
                end
            end
            if (i == 1) begin
                n_tests++;
                if ({out_valid, out_is_load} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL stream_first_ld got %b want 11",
                             {out_valid, out_is_load});
                end
            end
        end
        n_tests++;
        if ({stream_done, drained, overflow} !== 3'b110) begin
            n_fail++;
            $display("FAIL stream_end got %b want 110",
                     {stream_done, drained, overflow});
        end
    endtask

    task automatic test_hold();
        logic [21:0] g, e;
        do_reset(2);
        for (int i = 0; i < 8; i++) step(prog[i], 1'b0);
        step(12'h000, 1'b0);
        n_tests++;
        if ({occupancy, overflow} !== {4'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_occ got %0d/%b want 7/0", occupancy, overflow);
        end
        for (int i = 0; i < 9; i++) begin
            step(12'h000, 1'b1);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL hold_drain cyc %0d got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [21:0] g, e;
        do_reset(2);
        for (int i = 0; i < 11; i++) begin
            step(mk(i % 6, i % 8, (i + 1) % 8, (i + 3) % 8), 1'b0);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL overflow cyc %0d got %h want %h", i, g, e);
            end
        end
        n_tests++;
        if ({occupancy, overflow} !== {4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_flag got %0d/%b want 8/1", occupancy, overflow);
        end
        step(mk(7, 0, 0, 0), 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(12'h000, 1'b1);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL overflow_drain cyc %0d got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [21:0] g, e;
        do_reset(2);
        for (int i = 0; i < 9; i++) step(mk(1, i % 8, 2, 3), 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(mk(4, 7 - i, i, 1), 1'b1);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL full_pp cyc %0d got %h want %h", i, g, e);
            end
        end
        n_tests++;
        if ({occupancy, overflow} !== {4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL full_pp_flag got %0d/%b want 8/0", occupancy, overflow);
        end
    endtask

    task automatic test_zeros();
        logic [21:0] g, e;
        do_reset(2);
        for (int i = 0; i < 4; i++) step(12'h000, 1'b0);
        n_tests++;
        if (occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL zeros_idle got %0d want 0", occupancy);
        end
        step(mk(2, 1, 2, 3), 1'b0);
        step(12'h000, 1'b0);
        step(mk(3, 4, 5, 6), 1'b0);
        step(mk(7, 0, 0, 0), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(12'h000, 1'b1);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL zeros cyc %0d got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] g, e;
        do_reset(2);
        for (int i = 0; i < 4; i++) step(mk(0, i, 1, 2), 1'b0);
        n_tests++;
        if (occupancy !== 4'd3) begin
            n_fail++;
            $display("FAIL rmid_pre got %0d want 3", occupancy);
        end
        reset = 1'b1;
        #2;
        n_tests++;
        if ({out_valid, occupancy, stream_done} !== 6'd0) begin
            n_fail++;
            $display("FAIL rmid_async got %b want 0",
                     {out_valid, occupancy, stream_done});
        end
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(i < 3 ? 12'h000 : mk(5, 3, 0, 7), 1'b0);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL rmid cyc %0d got %h want %h", i, g, e);
            end
        end
    endtask

`ifdef RX_ILLEGAL_TRAP_EN
    task automatic test_illegal();
        logic [21:0] g, e;
        do_reset(2);
        step(mk(0, 1, 2, 3), 1'b0);
        step(mk(6, 1, 1, 1), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(mk(1, 2, 3, 4), 1'b0);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL illegal cyc %0d got %h want %h", i, g, e);
            end
        end
        n_tests++;
        if ({ill_w, occupancy} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL illegal_flag got %b/%0d want 1/1", ill_w, occupancy);
        end
    endtask
`endif

    task automatic test_random();
        logic [21:0] g, e;
        logic [11:0] w;
        logic        rdy;
        int          op;
        do_reset(2);
        step(mk(3, 1, 1, 1), 1'b0);
        for (int i = 0; i < 300; i++) begin
`ifdef RX_ILLEGAL_TRAP_EN
            op = $urandom_range(0, 5);
`else
            op = $urandom_range(0, 6);
`endif
            w = ($urandom_range(0, 7) == 0) ? 12'h000 :
                mk(op, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7));
            rdy = ((i / 40) % 2 == 1) ? ($urandom_range(0, 5) == 0)
                                      : ($urandom_range(0, 2) != 0);
            step(w, rdy);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL random cyc %0d got %h want %h", i, g, e);
            end
        end
        step(mk(7, 0, 0, 0), 1'b1);
        for (int i = 0; i < 12; i++) begin
            step($urandom_range(0, 4095), 1'b1);
            g = got_vec();
            e = exp_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL random_drain cyc %0d got %h want %h", i, g, e);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        io_in     = '0;
        out_ready = 1'b0;
        model_clear();
        prog[0] = mk(5, 0, 0, 0);
        prog[1] = mk(0, 1, 0, 2);
        prog[2] = mk(1, 2, 1, 1);
        prog[3] = mk(3, 4, 2, 3);
        prog[4] = mk(5, 5, 0, 3);
        prog[5] = mk(4, 6, 4, 5);
        prog[6] = mk(2, 3, 7, 6);
        prog[7] = mk(7, 0, 0, 0);
        test_reset();
        test_stream();
        test_hold();
        test_overflow();
        test_full_push_pop();
        test_zeros();
        test_reset_mid();
`ifdef RX_ILLEGAL_TRAP_EN
        test_illegal();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
